cam_alloc: RTL and testbench
============================

CAM_ALLOC -- requirements
Module: cam_alloc

Interface
REQ-001 SHALL have parameter: SIZE, 8, number of entries (>=2, need not be a power of two).
REQ-002 SHALL have parameter: WIDTH, 32, key width in bits.
REQ-003 SHALL use local constant IDX_W = $clog2(SIZE) for index widths.
REQ-004 SHALL have port: clock  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: enable  input  1  command strobe, one command per cycle, no backpressure.
REQ-007 SHALL have port: command  input  cam_cmd_e (2)  SEARCH, INSERT, DELETE or CLEAR.
REQ-008 SHALL have port: key  input  WIDTH  lookup/insert key.
REQ-009 SHALL have port: resp_valid  output  1  response strobe.
REQ-010 SHALL have port: resp_idx  output  IDX_W  result index.
REQ-011 SHALL have port: hit  output  1  key matched a valid entry.
REQ-012 SHALL have port: multi_hit  output  1  more than one valid entry matched.
REQ-013 SHALL have port: error  output  1  INSERT rejected because the table was full.
REQ-014 SHALL have port: count  output  IDX_W+1  number of valid entries.
REQ-015 SHALL have ports: full, empty  output  1 each  count==SIZE, count==0.

Function
REQ-016 SHALL accept a command on any rising edge with enable=1 and reset=0.
REQ-017 SHALL assert resp_valid for exactly one cycle, one cycle after each accepted command (latency 1, throughput 1/cycle).
REQ-018 SHALL drive resp_idx=0, hit=0, multi_hit=0, error=0 in cycles where resp_valid=0.
REQ-019 SHALL compare key against all entries using valid bits and contents as they were before the accepting edge.
REQ-020 SEARCH SHALL change no state and return hit, the lowest matching index and multi_hit.
REQ-021 INSERT with key already present SHALL change no state and return hit=1 and the lowest matching index.
REQ-022 INSERT with key absent and not full SHALL write key into the lowest-index invalid entry, set its valid bit, increment count, and return hit=0 with that index.
REQ-023 INSERT with key absent and full SHALL change no state and return error=1, hit=0, resp_idx=0.
REQ-024 DELETE SHALL clear the valid bit of every matching entry, reduce count by the number cleared, and return hit, the lowest matching index and multi_hit. A miss returns hit=0 and resp_idx=0.
REQ-025 CLEAR SHALL clear all valid bits, set count=0, and return hit=0 and resp_idx=0.
REQ-026 SHALL update count, full and empty on the same edge as the valid bits, so the values are visible together with resp_valid.
REQ-027 A command accepted in cycle N+1 SHALL observe state changes made by the command of cycle N. Back-to-back INSERT then SEARCH of the same key SHALL hit.
REQ-028 The invalid-entry contents SHALL never produce a hit.

Reset
REQ-029 Reset SHALL clear all valid bits and set count=0, empty=1, full=0, resp_valid=0, resp_idx=0, hit=0, multi_hit=0, error=0.
REQ-030 Reset SHALL leave entry key storage uninitialised.
REQ-031 A command presented while reset=1 SHALL be discarded, with no response in the following cycle.
REQ-032 Reset asserted the cycle after a command SHALL suppress that command's response.

Structure
REQ-033 Package cam_pkg SHALL hold the cam_cmd_e typedef with encodings SEARCH=0, INSERT=1, DELETE=2, CLEAR=3.
REQ-034 Sub-module cam_prio_enc (parametrised by SIZE) SHALL provide the lowest-set-bit index, any-set and more-than-one-set outputs.
REQ-035 cam_prio_enc SHALL be instantiated twice: once on the match vector and once on the inverted valid vector.

Verification (SIZE=4, WIDTH=8)
REQ-036 Reset, SEARCH 0x00 -> resp_valid=1, hit=0, empty=1, count=0.
REQ-037 INSERT 0xA1,0xB2,0xC3,0xD4 back-to-back -> resp_idx 0,1,2,3, hit=0. After the last response: full=1, count=4. Then INSERT 0xE5 -> error=1, count=4.
REQ-038 DELETE 0xB2, then INSERT 0xE5 -> DELETE gives hit=1, idx=1. INSERT gives idx=1. SEARCH 0xE5 -> hit=1, idx=1.
REQ-039 INSERT 0xA1 when present at idx 0 -> hit=1, idx=0, count unchanged. Force a duplicate via CLEAR then two INSERTs of 0x77 -> second hit=1. multi_hit stays 0.
REQ-040 INSERT 0x55 with reset asserted in the next cycle -> no resp_valid, count=0, SEARCH 0x55 -> hit=0.
REQ-041 CLEAR on a full table -> count=0, empty=1. SEARCH of any former key -> hit=0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared command encoding for the allocating CAM.
package cam_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    INSERT = 2'd1,
    DELETE = 2'd2,
    CLEAR  = 2'd3
  } cam_cmd_e;

endpackage : cam_pkg

// File: rtl/cam_prio_enc.sv
// Priority encoder: index of the lowest set bit, plus any-set and more-than-one-set flags.
module cam_prio_enc #(
  parameter  int SIZE  = 8,
  localparam int IDX_W = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]  vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  // Scan from the top down so the lowest set bit is the one left standing.
  // The bit trick vec & (vec-1) drops the lowest set bit; anything left means two or more.
  always_comb begin
    idx = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    any   = |vec;
    multi = |(vec & (vec - {{(SIZE-1){1'b0}}, 1'b1}));
  end

endmodule : cam_prio_enc

// File: rtl/cam_alloc.sv
// Allocating CAM: parallel key compare over all entries, with insert into the
// lowest free slot, delete-by-key and whole-table clear. One response per
// accepted command, one cycle later.
module cam_alloc
  import cam_pkg::*;
#(
  parameter  int SIZE  = 8,
  parameter  int WIDTH = 32,
  localparam int IDX_W = $clog2(SIZE)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  cam_cmd_e         command,
  input  logic [WIDTH-1:0] key,
  output logic             resp_valid,
  output logic [IDX_W-1:0] resp_idx,
  output logic             hit,
  output logic             multi_hit,
  output logic             error,
  output logic [IDX_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [IDX_W:0] SIZE_C = (IDX_W + 1)'(SIZE);

  // Key storage has no reset; the valid bits alone decide whether an entry exists.
  logic [WIDTH-1:0] keys_q [SIZE];
  logic [SIZE-1:0]  valid_q, valid_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IDX_W-1:0] resp_idx_q, resp_idx_d;
  logic             hit_q, hit_d;
  logic             multi_q, multi_d;
  logic             error_q, error_d;
  logic             wr_en;

  logic [SIZE-1:0]  match;
  logic [IDX_W-1:0] match_idx, free_idx;
  logic             match_any, match_multi, free_any, free_multi;

  // One comparator per entry; an invalid entry can never match whatever it holds.
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_match
    assign match[gi] = valid_q[gi] && (keys_q[gi] == key);
  end

  cam_prio_enc #(.SIZE(SIZE)) u_match_enc (
    .vec   (match),
    .idx   (match_idx),
    .any   (match_any),
    .multi (match_multi)
  );

  cam_prio_enc #(.SIZE(SIZE)) u_free_enc (
    .vec   (~valid_q),
    .idx   (free_idx),
    .any   (free_any),
    .multi (free_multi)
  );

  // Decode the command against the pre-edge table and work out the next valid set and response.
  always_comb begin
    valid_d      = valid_q;
    resp_valid_d = 1'b0;
    resp_idx_d   = '0;
    hit_d        = 1'b0;
    multi_d      = 1'b0;
    error_d      = 1'b0;
    wr_en        = 1'b0;
    if (enable) begin
      resp_valid_d = 1'b1;
      unique case (command)
        SEARCH: begin
          hit_d      = match_any;
          resp_idx_d = match_any ? match_idx : '0;
          multi_d    = match_multi;
        end
        INSERT: begin
          if (match_any) begin
            hit_d      = 1'b1;
            resp_idx_d = match_idx;
          end else if (free_any) begin
            wr_en             = 1'b1;
            valid_d[free_idx] = 1'b1;
            resp_idx_d        = free_idx;
          end else begin
            error_d = 1'b1;
          end
        end
        DELETE: begin
          valid_d    = valid_q & ~match;
          hit_d      = match_any;
          resp_idx_d = match_any ? match_idx : '0;
          multi_d    = match_multi;
        end
        CLEAR: begin
          valid_d = '0;
        end
        default: ;
      endcase
    end
  end

  // Count is the population of the next valid set, so it lands on the same edge as the bits.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < SIZE; i++) begin
      count_d = count_d + {{IDX_W{1'b0}}, valid_d[i]};
    end
  end

  // Control and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q      <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
      hit_q        <= 1'b0;
      multi_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_idx_q   <= resp_idx_d;
      hit_q        <= hit_d;
      multi_q      <= multi_d;
      error_q      <= error_d;
    end
  end

  // Key write port; a write issued just before reset is harmless because its valid bit is dropped.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) keys_q[free_idx] <= key;
  end

  // A reset arriving in the response cycle squashes the pending response.
  always_comb begin
    resp_valid = resp_valid_q & ~reset;
    resp_idx   = resp_valid ? resp_idx_q : '0;
    hit        = resp_valid & hit_q;
    multi_hit  = resp_valid & multi_q;
    error      = resp_valid & error_q;
    count      = count_q;
    full       = (count_q == SIZE_C);
    empty      = (count_q == '0);
  end

  logic unused_free_multi;
  assign unused_free_multi = free_multi;

endmodule : cam_alloc

// File: tb/tb_cam_alloc.sv
// Self-checking bench for cam_alloc (SIZE=4, WIDTH=8): directed scenarios then random traffic,
// all checked against a table-of-entries reference model.
module tb_cam_alloc;
  import cam_pkg::*;

  localparam int SIZE  = 4;
  localparam int WIDTH = 8;
  localparam int IDX_W = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  cam_cmd_e         command = SEARCH;
  logic [WIDTH-1:0] key = '0;
  logic             resp_valid;
  logic [IDX_W-1:0] resp_idx;
  logic             hit, multi_hit, error, full, empty;
  logic [IDX_W:0]   count;

  cam_alloc #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .command    (command),
    .key        (key),
    .resp_valid (resp_valid),
    .resp_idx   (resp_idx),
    .hit        (hit),
    .multi_hit  (multi_hit),
    .error      (error),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: a plain table of entries with a present flag and a key.
  bit               m_valid [SIZE];
  logic [WIDTH-1:0] m_key   [SIZE];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < SIZE; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  // Apply one command to the model and return what the CAM should answer.
  task automatic model_apply(input cam_cmd_e c, input logic [WIDTH-1:0] k,
                             output int e_idx, output bit e_hit, output bit e_multi,
                             output bit e_err);
    int nm = 0;
    int first = -1;
    int free = -1;
    for (int i = 0; i < SIZE; i++) begin
      if (m_valid[i] && m_key[i] == k) begin
        if (first < 0) first = i;
        nm++;
      end
      if (!m_valid[i] && free < 0) free = i;
    end
    e_idx = 0; e_hit = 0; e_multi = 0; e_err = 0;
    case (c)
      SEARCH: begin
        e_hit = (nm > 0); e_idx = (first < 0) ? 0 : first; e_multi = (nm > 1);
      end
      INSERT: begin
        if (nm > 0) begin
          e_hit = 1; e_idx = first;
        end else if (free >= 0) begin
          m_valid[free] = 1; m_key[free] = k; e_idx = free;
        end else begin
          e_err = 1;
        end
      end
      DELETE: begin
        e_hit = (nm > 0); e_idx = (first < 0) ? 0 : first; e_multi = (nm > 1);
        for (int i = 0; i < SIZE; i++) if (m_valid[i] && m_key[i] == k) m_valid[i] = 0;
      end
      default: begin
        for (int i = 0; i < SIZE; i++) m_valid[i] = 0;
      end
    endcase
  endtask

  task automatic check_state(input string tag);
    int mc = m_count();
    chk({tag, ".count"}, 32'(count), 32'(mc));
    chk({tag, ".full"},  32'(full),  32'(mc == SIZE));
    chk({tag, ".empty"}, 32'(empty), 32'(mc == 0));
  endtask

  // Issue one command, check its response one cycle later, and print one line for it.
  task automatic do_cmd(input cam_cmd_e c, input logic [WIDTH-1:0] k, input string tag);
    int  e_idx;
    bit  e_hit, e_multi, e_err;
    enable = 1'b1; command = c; key = k;
    model_apply(c, k, e_idx, e_hit, e_multi, e_err);
    @(posedge clock); #1;
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".resp_idx"},   32'(resp_idx),   32'(e_idx));
    chk({tag, ".hit"},        32'(hit),        32'(e_hit));
    chk({tag, ".multi_hit"},  32'(multi_hit),  32'(e_multi));
    chk({tag, ".error"},      32'(error),      32'(e_err));
    check_state(tag);
    $display("%s cmd=%s key=%02h -> idx=%0d hit=%0b multi=%0b err=%0b count=%0d",
             tag, c.name(), k, resp_idx, hit, multi_hit, error, count);
    enable = 1'b0;
  endtask

  task automatic idle(input string tag);
    enable = 1'b0;
    @(posedge clock); #1;
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, ".quiet"}, {28'd0, resp_idx, hit, multi_hit, error}, 32'd0);
    check_state(tag);
  endtask

  initial begin
    cam_cmd_e   rc;
    logic [7:0] rk;
    for (int i = 0; i < SIZE; i++) begin m_valid[i] = 0; m_key[i] = '0; end

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.full",  32'(full),  32'd0);
    chk("rst.outs", {28'd0, resp_idx, hit, multi_hit, error}, 32'd0);
    reset = 1'b0;

    do_cmd(SEARCH, 8'h00, "search_empty");

    // Fill the table back-to-back, then overflow
    do_cmd(INSERT, 8'hA1, "ins0");
    do_cmd(INSERT, 8'hB2, "ins1");
    do_cmd(INSERT, 8'hC3, "ins2");
    do_cmd(INSERT, 8'hD4, "ins3");
    chk("fill.full_const", 32'(full), 32'd1);
    do_cmd(INSERT, 8'hE5, "ins_full");
    chk("ins_full.error_const", 32'(error), 32'd1);

    // Hole reuse
    do_cmd(DELETE, 8'hB2, "del_b2");
    do_cmd(INSERT, 8'hE5, "ins_hole");
    chk("ins_hole.idx_const", 32'(resp_idx), 32'd1);
    do_cmd(SEARCH, 8'hE5, "search_e5");

    // Duplicate insert, clear, double insert
    do_cmd(INSERT, 8'hA1, "ins_dup");
    do_cmd(DELETE, 8'h99, "del_miss");
    do_cmd(CLEAR,  8'h00, "clear1");
    do_cmd(INSERT, 8'h77, "ins77a");
    do_cmd(INSERT, 8'h77, "ins77b");
    do_cmd(SEARCH, 8'h77, "search77");
    idle("idle1");

    // Reset in the cycle after an INSERT squashes its response and its entry
    do_cmd(CLEAR, 8'h00, "clear2");
    enable = 1'b1; command = INSERT; key = 8'h55;
    @(posedge clock); #1;
    reset = 1'b1; enable = 1'b0;
    #1;
    chk("rst_after.resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clock); #1;
    chk("rst_after.resp_valid2", 32'(resp_valid), 32'd0);
    chk("rst_after.count", 32'(count), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < SIZE; i++) m_valid[i] = 0;
    do_cmd(SEARCH, 8'h55, "search55");

    // Command presented during reset is discarded
    reset = 1'b1; enable = 1'b1; command = INSERT; key = 8'h66;
    @(posedge clock); #1;
    reset = 1'b0; enable = 1'b0;
    idle("rst_cmd");

    // Clear on a full table
    do_cmd(INSERT, 8'h10, "f0");
    do_cmd(INSERT, 8'h20, "f1");
    do_cmd(INSERT, 8'h30, "f2");
    do_cmd(INSERT, 8'h40, "f3");
    do_cmd(CLEAR,  8'h00, "clear_full");
    do_cmd(SEARCH, 8'h30, "search_old");

    // Random traffic over a small key pool so hits, fills and deletes all happen
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle("rnd_idle");
      end else begin
        rc = ($urandom_range(0, 15) == 0) ? CLEAR : cam_cmd_e'($urandom_range(0, 2));
        rk = 8'($urandom_range(0, 6)) + 8'h30;
        do_cmd(rc, rk, "rnd");
      end
    end
    idle("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_cam_alloc
